// File: rtl/rib_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the rib round-robin arbiter.
package rib_rr_arbiter_pkg;

  localparam int RIB_NUM_M     = 4;
  localparam int IDX_W         = $clog2(RIB_NUM_M);
  localparam int CNT_W         = 3;
  localparam int MAX_BURST_DEF = 4;

  // Reset is asserted when rst equals this level.
  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] lim);
    return (cnt >= lim) ? lim : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rib_rr_arbiter_if.sv
// Request/grant bundle between the rib masters and the round-robin arbiter.
interface rib_rr_arbiter_if;
  import rib_rr_arbiter_pkg::*;

  logic [RIB_NUM_M-1:0] req_i;
  logic                 ready_i;
  logic [RIB_NUM_M-1:0] gnt_o;
  logic [IDX_W-1:0]     gnt_idx_o;
  logic                 gnt_valid_o;
  logic [CNT_W-1:0]     burst_cnt_o;
  logic                 hold_flag_o;

  modport master (
    output req_i, ready_i,
    input  gnt_o, gnt_idx_o, gnt_valid_o, burst_cnt_o, hold_flag_o
  );

  modport slave (
    input  req_i, ready_i,
    output gnt_o, gnt_idx_o, gnt_valid_o, burst_cnt_o, hold_flag_o
  );

endinterface

// File: rtl/rib_rr_arbiter_rr_pick.sv
// Combinational cyclic priority pick: first set request at or after i_start.
module rib_rr_arbiter_rr_pick
  import rib_rr_arbiter_pkg::*;
(
  input  logic [RIB_NUM_M-1:0] i_req,
  input  logic [IDX_W-1:0]     i_start,
  output logic [RIB_NUM_M-1:0] o_pick,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_found
);

  logic [2*RIB_NUM_M-1:0] w_dbl;
  logic [RIB_NUM_M-1:0]   w_rot;
  logic [IDX_W-1:0]       w_off;

  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_start +: RIB_NUM_M];

  always_comb begin
    w_off = '0;
    for (int i = RIB_NUM_M - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  // Un-rotate relies on RIB_NUM_M being a power of two so the add wraps.
  assign o_found = |w_rot;
  assign o_idx   = i_start + w_off;
  assign o_pick  = o_found ? (RIB_NUM_M'(1) << o_idx) : '0;

endmodule

// File: rtl/rib_rr_arbiter.sv
// Round-robin arbiter for the four rib masters with per-tenure burst limit
// and core hold flag.
module rib_rr_arbiter
  import rib_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  rib_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(MAX_BURST);

  arb_state_e           r_state;
  logic [RIB_NUM_M-1:0] r_gnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_valid;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_last;

  logic [IDX_W-1:0]     w_start;
  logic [RIB_NUM_M-1:0] w_pick;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_found;
  logic                 w_req_g;
  logic                 w_others;
  logic [CNT_W:0]       w_cnt_sum;
  logic                 w_keep;
  logic [CNT_W-1:0]     w_cnt_sat;

  // While granted, search from g+1 so the current owner is considered last.
  assign w_start = (r_state == ARB_GRANT) ? r_idx + IDX_W'(1) : r_last + IDX_W'(1);

  rib_rr_arbiter_rr_pick u_pick (
    .i_req   (bus.req_i),
    .i_start (w_start),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  assign w_req_g   = bus.req_i[r_idx];
  assign w_others  = |(bus.req_i & ~r_gnt);
  assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_keep    = (w_cnt_sum < (CNT_W+1)'(MAX_BURST)) || !w_others;
  assign w_cnt_sat = sat_inc(r_cnt, L_MAX);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_last  <= IDX_W'(RIB_NUM_M - 1);
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_pick;
            r_idx   <= w_pick_idx;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!w_req_g) begin
            r_last <= r_idx;
            if (w_found) begin
              r_gnt <= w_pick;
              r_idx <= w_pick_idx;
              r_cnt <= '0;
            end else begin
              // Idle keeps the final count visible; gnt_idx holds its value.
              r_gnt   <= '0;
              r_valid <= 1'b0;
              r_state <= ARB_IDLE;
              if (bus.ready_i) r_cnt <= w_cnt_sat;
            end
          end else if (bus.ready_i) begin
            if (w_keep) begin
              r_cnt <= w_cnt_sat;
            end else begin
              r_last <= r_idx;
              r_gnt  <= w_pick;
              r_idx  <= w_pick_idx;
              r_cnt  <= '0;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.gnt_idx_o   = r_idx;
  assign bus.gnt_valid_o = r_valid;
  assign bus.burst_cnt_o = r_cnt;
  assign bus.hold_flag_o = (rst != RST_ENABLE) && (|(bus.req_i[1:0] & ~r_gnt[1:0]));

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Scoreboard bench for rib_rr_arbiter: two instances (burst limit 4 and 1)
// driven identically and checked against a cycle-level reference model.
module tb_rib_rr_arbiter;
  import rib_rr_arbiter_pkg::*;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic [2:0] cnt;
    logic       hold;
  } exp_t;

  logic       clk = 1'b0;
  logic       tb_rst;
  logic [3:0] tb_req;
  logic       tb_rdy;

  int checks   = 0;
  int failures = 0;

  exp_t q4[$];
  exp_t q1[$];

  int mb[2] = '{4, 1};
  int m_vld[2];
  int m_idx[2];
  int m_last[2];
  int m_cnt[2];

  rib_rr_arbiter_if bus4();
  rib_rr_arbiter_if bus1();

  assign bus4.req_i   = tb_req;
  assign bus4.ready_i = tb_rdy;
  assign bus1.req_i   = tb_req;
  assign bus1.ready_i = tb_rdy;

  rib_rr_arbiter #(.MAX_BURST(4)) u_dut4 (.clk(clk), .rst(tb_rst), .bus(bus4));
  rib_rr_arbiter #(.MAX_BURST(1)) u_dut1 (.clk(clk), .rst(tb_rst), .bus(bus1));

  initial forever #5 clk = ~clk;

  function automatic int search(input int from, input logic [3:0] rq);
    for (int k = 1; k <= 4; k++) begin
      if (rq[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic int inc_sat(input int c, input int lim);
    return (c + 1 > lim) ? lim : c + 1;
  endfunction

  task automatic model_step();
    int g, p;
    bit others;
    for (int n = 0; n < 2; n++) begin
      if (!tb_rst) begin
        m_vld[n] = 0; m_idx[n] = 0; m_last[n] = 3; m_cnt[n] = 0;
      end else if (m_vld[n] == 0) begin
        p = search(m_last[n], tb_req);
        if (p >= 0) begin
          m_vld[n] = 1; m_idx[n] = p; m_cnt[n] = 0;
        end
      end else begin
        g = m_idx[n];
        others = (tb_req & ~(4'b0001 << g)) != 4'b0000;
        if (!tb_req[g]) begin
          m_last[n] = g;
          p = search(g, tb_req);
          if (p >= 0) begin
            m_idx[n] = p; m_cnt[n] = 0;
          end else begin
            m_vld[n] = 0;
            if (tb_rdy) m_cnt[n] = inc_sat(m_cnt[n], mb[n]);
          end
        end else if (tb_rdy) begin
          if ((m_cnt[n] + 1 < mb[n]) || !others) begin
            m_cnt[n] = inc_sat(m_cnt[n], mb[n]);
          end else begin
            m_last[n] = g;
            m_idx[n]  = search(g, tb_req);
            m_cnt[n]  = 0;
          end
        end
      end
    end
  endtask

  function automatic exp_t expect_of(input int n);
    exp_t e;
    e.gnt  = m_vld[n] != 0 ? (4'b0001 << m_idx[n]) : 4'b0000;
    e.idx  = 2'(m_idx[n]);
    e.vld  = m_vld[n] != 0;
    e.cnt  = 3'(m_cnt[n]);
    e.hold = tb_rst && (|(tb_req[1:0] & ~e.gnt[1:0]));
    return e;
  endfunction

  task automatic step(input logic r, input logic [3:0] rq, input logic rd);
    @(posedge clk);
    model_step();
    #1;
    tb_rst = r;
    tb_req = rq;
    tb_rdy = rd;
    q4.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [3:0] g,
                     input logic [1:0] i, input logic v, input logic [2:0] c,
                     input logic h);
    chk({tag, ".gnt"},  ^g === 1'bx ? -1 : int'(g), int'(e.gnt));
    chk({tag, ".idx"},  ^i === 1'bx ? -1 : int'(i), int'(e.idx));
    chk({tag, ".vld"},  v  === 1'bx ? -1 : int'(v), int'(e.vld));
    chk({tag, ".cnt"},  ^c === 1'bx ? -1 : int'(c), int'(e.cnt));
    chk({tag, ".hold"}, h  === 1'bx ? -1 : int'(h), int'(e.hold));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp("mb4", e, bus4.gnt_o, bus4.gnt_idx_o, bus4.gnt_valid_o, bus4.burst_cnt_o, bus4.hold_flag_o);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("mb1", e, bus1.gnt_o, bus1.gnt_idx_o, bus1.gnt_valid_o, bus1.burst_cnt_o, bus1.hold_flag_o);
    end
  end

  initial begin
    logic [3:0] rq;
    tb_rst = 1'b0;
    tb_req = 4'hF;
    tb_rdy = 1'b0;

    // reset with all masters requesting, then release
    repeat (3) step(1'b0, 4'hF, 1'b0);
    repeat (3) step(1'b1, 4'hF, 1'b0);

    // single master m2, completion with request drop
    repeat (2) step(1'b1, 4'h0, 1'b0);
    repeat (3) step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h0, 1'b1);
    repeat (2) step(1'b1, 4'h0, 1'b0);

    // all requesting, ready every cycle: burst rotation
    repeat (20) step(1'b1, 4'hF, 1'b1);

    // sole requester m1: saturation, no rotation
    repeat (2) step(1'b1, 4'h0, 1'b0);
    repeat (22) step(1'b1, 4'h2, 1'b1);

    // m0 stalled by slave while m1 waits, then hand-over
    repeat (2) step(1'b1, 4'h0, 1'b0);
    step(1'b1, 4'h1, 1'b0);
    repeat (10) step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h2, 1'b1);
    repeat (2) step(1'b1, 4'h2, 1'b0);

    // reset in the middle of an m2 tenure resets the pointer
    repeat (2) step(1'b1, 4'h0, 1'b0);
    repeat (2) step(1'b1, 4'h4, 1'b0);
    step(1'b0, 4'h4, 1'b0);
    repeat (4) step(1'b1, 4'h5, 1'b0);

    // randomized traffic
    rq = 4'h0;
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 9) < 3) rq = 4'($urandom_range(0, 15));
      step($urandom_range(0, 49) != 0, rq, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drain", q4.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
